decode_stage_pipelined: RTL and testbench
=========================================

// Module: decode_stage_pipelined
// PURPOSE
//  Parametrised ID stage for the 5-stage MIPS pipeline, sitting between IF/ID and EX.
//  Contains the register file with write-through bypass, main control decode, early
//  branch resolution for BEQ and BNE, and load-use/branch hazard stalling.
//  Results are latched into a registered ID/EX bundle, with bubble insertion and a
//  saturating stall-cycle counter.
// PARAMETERS
//  DATA_W      32  register/data width (>=16); immediates sign-extended to DATA_W
//  NUM_REGS    32  register count; register 0 reads as 0 and ignores writes
//  REG_ADDR_W   5  register index width; NUM_REGS <= 2**REG_ADDR_W
//  CNT_W       16  width of Stall_Count
// PORTS
//  Clk             in   1           clock, all state updates on posedge
//  Rst             in   1           synchronous reset, active-high
//  Instruction     in   32          IF/ID instruction word
//  InputAddress    in   32          IF/ID PC+4
//  If_Valid        in   1           IF/ID holds a real instruction
//  WriteReg        in   REG_ADDR_W  WB destination register
//  WriteData       in   DATA_W      WB data
//  WriteRegEnable  in   1           WB write enable
//  ExMem_MemRead   in   1           EX/MEM stage holds a load
//  ExMem_Rt        in   REG_ADDR_W  destination of that load
//  Stall           out  1           hold PC and IF/ID this cycle (comb.)
//  PCSrc           out  1           branch taken, select BranchAddress (comb.)
//  BranchAddress   out  32          InputAddress + (sext(imm16)<<2), mod 2**32
//  FlushIF         out  1           squash IF/ID next cycle (= PCSrc)
//  Ex_Valid        out  1           ID/EX holds a real instruction
//  Ex_ControlLines out  12          {RegWrite,ALUSrc,MemWrite,ALUOp[3:0],MemtoReg,MemRead,Branch,Jump,RegDst}
//  Ex_ReadData1/2  out  DATA_W      rs/rt operands
//  Ex_Imm          out  DATA_W      sign-extended imm16
//  Ex_Shamt        out  5           Instruction[10:6]
//  Ex_Rs/Ex_Rt/Ex_Rd out REG_ADDR_W source/dest indices for forwarding
//  Stall_Count     out  CNT_W       saturating count of Stall cycles since reset
// BEHAVIOUR
//  Reset: every regfile entry=0, all Ex_* outputs=0 (Ex_Valid=0 = bubble), Stall_Count=0.
//   Comb. outputs follow from this state.
//  Regfile:
//   - written at posedge when WriteRegEnable && WriteReg!=0.
//   - Reads are combinational; if WriteRegEnable && WriteReg==rs/rt != 0, the read
//     returns WriteData (same-cycle bypass).
//   - Indices >= NUM_REGS read 0 and are not written.
//  Decode (12'b RegWrite..RegDst):
//   - Instruction==0 (NOP) gives all zeros.
//   - R-type ADD 100_0000_00001, SUB 100_0001_00001, AND 100_0010_00001,
//     OR 100_0011_00001, SLL 100_0100_00001, SRL 100_0101_00001,
//     SRA 100_0110_00001, SLT 100_1000_00001.
//   - Other opcodes: BEQ 000_0001_00100, BNE 000_0001_00100, LW 110_0000_11000,
//     SW 011_0000_00000.
//   - Any other opcode/funct decodes to all zeros.
//  Branch: PCSrc = If_Valid & !Stall & Branch & (BEQ ? rs==rt : rs!=rt), using bypassed read values.
//  Hazards (srcs = rs and rt, ignoring index 0), Stall=1 when If_Valid and any of:
//   (a) Ex_Valid & Ex MemRead & Ex_Rt matches a src used by the instruction (load-use, 1 cycle)
//   (b) current is branch & Ex_Valid & Ex RegWrite & Ex dest (RegDst?Ex_Rd:Ex_Rt) matches a src
//   (c) current is branch & ExMem_MemRead & ExMem_Rt matches a src
//   A branch after a load therefore stalls exactly 2 cycles: (a)/(b), then (c).
//  ID/EX update at posedge:
//   - Stall or !If_Valid: bubble (Ex_Valid=0, Ex_ControlLines=0, other Ex_* don't care).
//   - Otherwise: latch the decoded bundle with Ex_Valid=1.
//   - Branches latch Branch=1 but no RegWrite.
//  Stall_Count += 1 on each Stall cycle and holds at 2**CNT_W-1.
//  Rst asserted while stalled: Stall drops, because Ex is cleared and ExMem inputs are
//   expected to be zero during reset.
// TESTING
//  1. Rst, then write r5=0x70 via WB, ADD r3,r5,r5 in the same cycle -> Ex_ReadData1/2=0x70
//     (bypass), Ex_ControlLines=0x801.
//  2. WB write to r0 with 0xFFFF, then read r0 -> 0; Instruction=0 -> Ex_Valid=1, Ex_ControlLines=0.
//  3. LW r2,0(r1) followed by ADD r4,r2,r1 -> Stall=1 for 1 cycle, bubble in ID/EX,
//     ADD issues next cycle, Stall_Count=1.
//  4. BEQ r1,r1,+3 at PC+4=0x100 with no hazard -> PCSrc=1, FlushIF=1, BranchAddress=0x10C;
//     BNE on equal regs -> PCSrc=0.
//  5. LW r2 then BEQ r2,r0,-1 -> Stall for 2 cycles, then PCSrc evaluated on the bypassed r2;
//     BranchAddress = PC+4-4.
//  6. CNT_W=2 with 5 stalled cycles -> Stall_Count saturates at 3; Rst mid-stall -> Ex_Valid=0,
//     Stall_Count=0 next cycle.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// rtl/decode_stage_pipelined.sv - MIPS ID stage: regfile with bypass, control decode, early branch, hazard stall, ID/EX register
module decode_stage_pipelined #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [31:0]           Instruction,
  input  logic [31:0]           InputAddress,
  input  logic                  If_Valid,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic                  WriteRegEnable,
  input  logic                  ExMem_MemRead,
  input  logic [REG_ADDR_W-1:0] ExMem_Rt,
  output logic                  Stall,
  output logic                  PCSrc,
  output logic [31:0]           BranchAddress,
  output logic                  FlushIF,
  output logic                  Ex_Valid,
  output logic [11:0]           Ex_ControlLines,
  output logic [DATA_W-1:0]     Ex_ReadData1,
  output logic [DATA_W-1:0]     Ex_ReadData2,
  output logic [DATA_W-1:0]     Ex_Imm,
  output logic [4:0]            Ex_Shamt,
  output logic [REG_ADDR_W-1:0] Ex_Rs,
  output logic [REG_ADDR_W-1:0] Ex_Rt,
  output logic [REG_ADDR_W-1:0] Ex_Rd,
  output logic [CNT_W-1:0]      Stall_Count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [DATA_W-1:0]     r_regs [NUM_REGS];

  logic [5:0]            w_opcode;
  logic [5:0]            w_funct;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0]     w_imm;
  logic [DATA_W-1:0]     w_rd1;
  logic [DATA_W-1:0]     w_rd2;
  logic [11:0]           w_ctl;
  logic                  w_is_branch;
  logic                  w_use_rs;
  logic                  w_use_rt;
  logic [REG_ADDR_W-1:0] w_ex_dest;
  logic                  w_haz_a;
  logic                  w_haz_b;
  logic                  w_haz_c;
  logic                  w_issue;

  assign w_opcode = Instruction[31:26];
  assign w_funct  = Instruction[5:0];
  assign w_rs     = REG_ADDR_W'(Instruction[25:21]);
  assign w_rt     = REG_ADDR_W'(Instruction[20:16]);
  assign w_rd     = REG_ADDR_W'(Instruction[15:11]);
  assign w_imm    = DATA_W'($signed(Instruction[15:0]));

  function automatic logic in_range(input logic [REG_ADDR_W-1:0] idx);
    logic ok;
    ok = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == REG_ADDR_W'(i)) ok = 1'b1;
    end
    return ok;
  endfunction

  // Register 0 and out-of-range indices never match, so they always read 0.
  function automatic logic [DATA_W-1:0] rf_read(input logic [REG_ADDR_W-1:0] idx);
    if (!in_range(idx)) return '0;
    if (WriteRegEnable && WriteReg == idx) return WriteData;
    return r_regs[idx];
  endfunction

  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] idx,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rt,
                                   input logic use_rs, input logic use_rt);
    return (idx != '0) && ((use_rs && idx == rs) || (use_rt && idx == rt));
  endfunction

  assign w_rd1 = rf_read(w_rs);
  assign w_rd2 = rf_read(w_rt);

  always_comb begin
    w_ctl = '0;
    case (w_opcode)
      OP_RTYPE: begin
        if (Instruction != 32'd0) begin
          case (w_funct)
            6'h20:   w_ctl = {3'b100, 4'd0, 5'b00001};
            6'h22:   w_ctl = {3'b100, 4'd1, 5'b00001};
            6'h24:   w_ctl = {3'b100, 4'd2, 5'b00001};
            6'h25:   w_ctl = {3'b100, 4'd3, 5'b00001};
            6'h00:   w_ctl = {3'b100, 4'd4, 5'b00001};
            6'h02:   w_ctl = {3'b100, 4'd5, 5'b00001};
            6'h03:   w_ctl = {3'b100, 4'd6, 5'b00001};
            6'h2A:   w_ctl = {3'b100, 4'd8, 5'b00001};
            default: w_ctl = '0;
          endcase
        end
      end
      OP_BEQ:  w_ctl = {3'b000, 4'd1, 5'b00100};
      OP_BNE:  w_ctl = {3'b000, 4'd1, 5'b00100};
      OP_LW:   w_ctl = {3'b110, 4'd0, 5'b11000};
      OP_SW:   w_ctl = {3'b011, 4'd0, 5'b00000};
      default: w_ctl = '0;
    endcase
  end

  // rt is a source for R-type, stores and branches; loads only read rs.
  assign w_is_branch = w_ctl[2];
  assign w_use_rs    = |w_ctl;
  assign w_use_rt    = w_ctl[0] | w_ctl[9] | w_ctl[2];
  assign w_ex_dest   = Ex_ControlLines[0] ? Ex_Rd : Ex_Rt;

  assign w_haz_a = Ex_Valid & Ex_ControlLines[3] & src_hit(Ex_Rt, w_rs, w_rt, w_use_rs, w_use_rt);
  assign w_haz_b = w_is_branch & Ex_Valid & Ex_ControlLines[11] &
                   src_hit(w_ex_dest, w_rs, w_rt, w_use_rs, w_use_rt);
  assign w_haz_c = w_is_branch & ExMem_MemRead & src_hit(ExMem_Rt, w_rs, w_rt, w_use_rs, w_use_rt);

  assign Stall         = If_Valid & (w_haz_a | w_haz_b | w_haz_c);
  assign PCSrc         = If_Valid & ~Stall & w_is_branch &
                         ((w_opcode == OP_BEQ) ? (w_rd1 == w_rd2) : (w_rd1 != w_rd2));
  assign FlushIF       = PCSrc;
  assign BranchAddress = InputAddress + {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
  assign w_issue       = If_Valid & ~Stall;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      Ex_Valid        <= 1'b0;
      Ex_ControlLines <= '0;
      Ex_ReadData1    <= '0;
      Ex_ReadData2    <= '0;
      Ex_Imm          <= '0;
      Ex_Shamt        <= '0;
      Ex_Rs           <= '0;
      Ex_Rt           <= '0;
      Ex_Rd           <= '0;
      Stall_Count     <= '0;
    end else begin
      if (WriteRegEnable && in_range(WriteReg)) r_regs[WriteReg] <= WriteData;
      Ex_Valid        <= w_issue;
      Ex_ControlLines <= w_issue ? w_ctl : 12'd0;
      Ex_ReadData1    <= w_rd1;
      Ex_ReadData2    <= w_rd2;
      Ex_Imm          <= w_imm;
      Ex_Shamt        <= Instruction[10:6];
      Ex_Rs           <= w_rs;
      Ex_Rt           <= w_rt;
      Ex_Rd           <= w_rd;
      if (Stall && Stall_Count != '1) Stall_Count <= Stall_Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb/tb_decode_stage_pipelined.sv - directed vector bench for decode_stage_pipelined
module tb_decode_stage_pipelined;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Instruction, InputAddress;
  logic        If_Valid, WriteRegEnable, ExMem_MemRead;
  logic [4:0]  WriteReg, ExMem_Rt;
  logic [31:0] WriteData;

  logic        Stall, PCSrc, FlushIF, Ex_Valid;
  logic [31:0] BranchAddress, Ex_ReadData1, Ex_ReadData2, Ex_Imm;
  logic [11:0] Ex_ControlLines;
  logic [4:0]  Ex_Shamt, Ex_Rs, Ex_Rt, Ex_Rd;
  logic [15:0] Stall_Count;

  logic        s2_stall, s2_pcsrc, s2_flush, s2_ex_valid;
  logic [31:0] s2_baddr, s2_rd1, s2_rd2, s2_imm;
  logic [11:0] s2_ctl;
  logic [4:0]  s2_shamt, s2_rs, s2_rt, s2_rd;
  logic [1:0]  s2_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  decode_stage_pipelined u_dut (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InputAddress(InputAddress),
    .If_Valid(If_Valid), .WriteReg(WriteReg), .WriteData(WriteData),
    .WriteRegEnable(WriteRegEnable), .ExMem_MemRead(ExMem_MemRead), .ExMem_Rt(ExMem_Rt),
    .Stall(Stall), .PCSrc(PCSrc), .BranchAddress(BranchAddress), .FlushIF(FlushIF),
    .Ex_Valid(Ex_Valid), .Ex_ControlLines(Ex_ControlLines), .Ex_ReadData1(Ex_ReadData1),
    .Ex_ReadData2(Ex_ReadData2), .Ex_Imm(Ex_Imm), .Ex_Shamt(Ex_Shamt), .Ex_Rs(Ex_Rs),
    .Ex_Rt(Ex_Rt), .Ex_Rd(Ex_Rd), .Stall_Count(Stall_Count)
  );

  decode_stage_pipelined #(.CNT_W(2)) u_dut_sat (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InputAddress(InputAddress),
    .If_Valid(If_Valid), .WriteReg(WriteReg), .WriteData(WriteData),
    .WriteRegEnable(WriteRegEnable), .ExMem_MemRead(ExMem_MemRead), .ExMem_Rt(ExMem_Rt),
    .Stall(s2_stall), .PCSrc(s2_pcsrc), .BranchAddress(s2_baddr), .FlushIF(s2_flush),
    .Ex_Valid(s2_ex_valid), .Ex_ControlLines(s2_ctl), .Ex_ReadData1(s2_rd1),
    .Ex_ReadData2(s2_rd2), .Ex_Imm(s2_imm), .Ex_Shamt(s2_shamt), .Ex_Rs(s2_rs),
    .Ex_Rt(s2_rt), .Ex_Rd(s2_rd), .Stall_Count(s2_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [11:0] ctl;
    logic [4:0]  shamt;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    Instruction    = 32'd0;
    InputAddress   = 32'd0;
    If_Valid       = 1'b0;
    WriteRegEnable = 1'b0;
    WriteReg       = 5'd0;
    WriteData      = 32'd0;
    ExMem_MemRead  = 1'b0;
    ExMem_Rt       = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    If_Valid       = 1'b0;
    WriteRegEnable = 1'b1;
    WriteReg       = r;
    WriteData      = d;
    tick();
    WriteRegEnable = 1'b0;
  endtask

  initial begin
    // sources r1/r3, destinations r9/r10 keep the table free of hazards
    vecs[0]  = '{rtype(1, 3, 10, 0, 6'h20), 12'h801, 5'd0};
    vecs[1]  = '{rtype(1, 3, 10, 0, 6'h22), 12'h821, 5'd0};
    vecs[2]  = '{rtype(1, 3, 10, 0, 6'h24), 12'h841, 5'd0};
    vecs[3]  = '{rtype(1, 3, 10, 0, 6'h25), 12'h861, 5'd0};
    vecs[4]  = '{rtype(0, 3, 10, 4, 6'h00), 12'h881, 5'd4};
    vecs[5]  = '{rtype(0, 3, 10, 2, 6'h02), 12'h8A1, 5'd2};
    vecs[6]  = '{rtype(0, 3, 10, 0, 6'h03), 12'h8C1, 5'd0};
    vecs[7]  = '{rtype(1, 3, 10, 0, 6'h2A), 12'h901, 5'd0};
    vecs[8]  = '{rtype(1, 3, 10, 0, 6'h21), 12'h000, 5'd0};
    vecs[9]  = '{itype(6'h04, 1, 3, 16'd2), 12'h024, 5'd0};
    vecs[10] = '{itype(6'h05, 1, 3, 16'd2), 12'h024, 5'd0};
    vecs[11] = '{itype(6'h23, 1, 9, 16'd4), 12'hC18, 5'd0};
    vecs[12] = '{itype(6'h2B, 1, 3, 16'd8), 12'h600, 5'd0};
    vecs[13] = '{32'h0800_0010,              12'h000, 5'd0};
    vecs[14] = '{32'h0000_0000,              12'h000, 5'd0};

    idle_inputs();
    Rst = 1'b1;
    tick();
    tick();
    chk("reset_ex_valid", Ex_Valid, 0);
    chk("reset_ctl", Ex_ControlLines, 0);
    chk("reset_count", Stall_Count, 0);
    chk("reset_stall", Stall, 0);
    chk("reset_pcsrc", PCSrc, 0);
    chk("reset_rd1", Ex_ReadData1, 0);
    Rst = 1'b0;

    // same-cycle write-through bypass
    WriteRegEnable = 1'b1; WriteReg = 5'd5; WriteData = 32'h70;
    Instruction = rtype(5, 5, 3, 0, 6'h20); If_Valid = 1'b1;
    settle();
    chk("bypass_stall", Stall, 0);
    tick();
    chk("bypass_rd1", Ex_ReadData1, 32'h70);
    chk("bypass_rd2", Ex_ReadData2, 32'h70);
    chk("bypass_ctl", Ex_ControlLines, 12'h801);
    chk("bypass_valid", Ex_Valid, 1);
    chk("bypass_exrd", Ex_Rd, 3);
    WriteRegEnable = 1'b0;
    Instruction = rtype(5, 0, 7, 0, 6'h20);
    tick();
    chk("stored_rd1", Ex_ReadData1, 32'h70);
    chk("stored_rd2_r0", Ex_ReadData2, 0);

    // r0 ignores writes, also in the bypass path
    WriteRegEnable = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF;
    Instruction = rtype(0, 0, 8, 0, 6'h20);
    tick();
    chk("r0_bypass", Ex_ReadData1, 0);
    WriteRegEnable = 1'b0;
    Instruction = rtype(0, 5, 8, 0, 6'h20);
    tick();
    chk("r0_read", Ex_ReadData1, 0);
    Instruction = 32'd0;
    tick();
    chk("nop_valid", Ex_Valid, 1);
    chk("nop_ctl", Ex_ControlLines, 0);
    Instruction = rtype(1, 3, 10, 0, 6'h20); If_Valid = 1'b0;
    tick();
    chk("ifinv_valid", Ex_Valid, 0);
    chk("ifinv_ctl", Ex_ControlLines, 0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      Instruction = vecs[i].instr; If_Valid = 1'b1;
      settle();
      chk($sformatf("vec%0d_stall", i), Stall, 0);
      tick();
      chk($sformatf("vec%0d_ctl", i), Ex_ControlLines, vecs[i].ctl);
      chk($sformatf("vec%0d_valid", i), Ex_Valid, 1);
      chk($sformatf("vec%0d_shamt", i), Ex_Shamt, vecs[i].shamt);
    end

    // load-use: one stall cycle, one bubble
    do_reset();
    Instruction = itype(6'h23, 1, 2, 16'd0); If_Valid = 1'b1;
    tick();
    Instruction = rtype(2, 1, 4, 0, 6'h20);
    settle();
    chk("lu_stall", Stall, 1);
    tick();
    chk("lu_bubble_valid", Ex_Valid, 0);
    chk("lu_bubble_ctl", Ex_ControlLines, 0);
    chk("lu_count", Stall_Count, 1);
    ExMem_MemRead = 1'b1; ExMem_Rt = 5'd2;
    settle();
    chk("lu_release", Stall, 0);
    tick();
    chk("lu_issue_ctl", Ex_ControlLines, 12'h801);
    chk("lu_issue_rd", Ex_Rd, 4);
    chk("lu_count_hold", Stall_Count, 1);
    ExMem_MemRead = 1'b0; ExMem_Rt = 5'd0;

    // early branch resolution
    do_reset();
    wb_write(5'd1, 32'd7);
    Instruction = itype(6'h04, 1, 1, 16'd3); InputAddress = 32'h100; If_Valid = 1'b1;
    settle();
    chk("beq_pcsrc", PCSrc, 1);
    chk("beq_flush", FlushIF, 1);
    chk("beq_addr", BranchAddress, 32'h10C);
    tick();
    Instruction = itype(6'h05, 1, 1, 16'd3);
    settle();
    chk("bne_eq_pcsrc", PCSrc, 0);
    Instruction = itype(6'h05, 1, 3, 16'd3);
    settle();
    chk("bne_ne_pcsrc", PCSrc, 1);
    Instruction = itype(6'h04, 1, 3, 16'd3);
    settle();
    chk("beq_ne_pcsrc", PCSrc, 0);
    Instruction = itype(6'h04, 1, 1, 16'd3); If_Valid = 1'b0;
    settle();
    chk("beq_ifinv_pcsrc", PCSrc, 0);
    If_Valid = 1'b1;
    Instruction = rtype(3, 3, 1, 0, 6'h20);
    tick();
    Instruction = itype(6'h04, 1, 1, 16'd3);
    settle();
    chk("alu_br_stall", Stall, 1);
    chk("alu_br_pcsrc", PCSrc, 0);
    tick();
    settle();
    chk("alu_br_release", Stall, 0);
    chk("alu_br_taken", PCSrc, 1);

    // load then branch: two stall cycles, then resolve on the bypassed load data
    do_reset();
    wb_write(5'd2, 32'd9);
    Instruction = itype(6'h23, 1, 2, 16'd0); InputAddress = 32'h1FC; If_Valid = 1'b1;
    tick();
    Instruction = itype(6'h04, 2, 0, 16'hFFFF); InputAddress = 32'h200;
    settle();
    chk("lb_stall1", Stall, 1);
    chk("lb_pcsrc1", PCSrc, 0);
    tick();
    chk("lb_bubble", Ex_Valid, 0);
    ExMem_MemRead = 1'b1; ExMem_Rt = 5'd2;
    settle();
    chk("lb_stall2", Stall, 1);
    tick();
    ExMem_MemRead = 1'b0; ExMem_Rt = 5'd0;
    WriteRegEnable = 1'b1; WriteReg = 5'd2; WriteData = 32'd0;
    settle();
    chk("lb_release", Stall, 0);
    chk("lb_pcsrc", PCSrc, 1);
    chk("lb_addr", BranchAddress, 32'h1FC);
    chk("lb_count", Stall_Count, 2);
    tick();
    WriteRegEnable = 1'b0;
    chk("lb_ex_ctl", Ex_ControlLines, 12'h024);
    chk("lb_ex_imm", Ex_Imm, 32'hFFFF_FFFF);
    chk("lb_ex_rd1", Ex_ReadData1, 0);

    // saturation and reset while stalled
    do_reset();
    Instruction = itype(6'h04, 2, 0, 16'hFFFF); If_Valid = 1'b1;
    ExMem_MemRead = 1'b1; ExMem_Rt = 5'd2;
    repeat (5) tick();
    settle();
    chk("sat_stall", Stall, 1);
    chk("sat_count16", Stall_Count, 5);
    chk("sat_count2", s2_count, 3);
    Rst = 1'b1; ExMem_MemRead = 1'b0; ExMem_Rt = 5'd0;
    settle();
    chk("rst_stall_drop", Stall, 0);
    tick();
    chk("rst_ex_valid", Ex_Valid, 0);
    chk("rst_count16", Stall_Count, 0);
    chk("rst_count2", s2_count, 0);
    Rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
